// File: rtl/latch_pkg.sv
// Shared definitions for the latch-bank write arbiter: FSM encoding, bank depth
// and the one-hot decode used for both latch enables and acknowledges.
package latch_pkg;

  localparam int NLAT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  function automatic logic [NLAT-1:0] onehot(input logic [1:0] idx);
    logic [NLAT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin selector: returns the first requester at or after ptr_i,
// wrapping modulo 4.
module rr_pick4
  import latch_pkg::*;
(
  input  logic [NLAT-1:0] req_i,
  input  logic [1:0]      ptr_i,
  output logic            valid_o,
  output logic [1:0]      idx_o
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the closest hit to ptr_i wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NLAT - 1; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/latch_wr_arbiter.sv
// Arbitrates four requesters onto a 4-entry latch bank with a safe
// setup / enable / hold write sequence and a registered one-cycle ack.
module latch_wr_arbiter
  import latch_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NLAT-1:0]   req,
  input  logic [NLAT*W-1:0] din,
  input  logic [2*NLAT-1:0] addr,
  output logic [W-1:0]      d,
  output logic [NLAT-1:0]   e,
  output logic [NLAT-1:0]   ack,
  output logic              busy,
  output logic [1:0]        gnt_id
);

  state_t          state_q, state_d;
  logic [W-1:0]    d_q, d_d;
  logic [NLAT-1:0] e_q, e_d;
  logic [NLAT-1:0] ack_q, ack_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      ptr_q, ptr_d;

  logic            pick_vld;
  logic [1:0]      pick_idx;

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  // Outputs are registered, so e/ack are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    e_d     = '0;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = SETUP;
          d_d     = din[int'(pick_idx)*W +: W];
          idx_d   = addr[int'(pick_idx)*2 +: 2];
          gnt_d   = pick_idx;
          ptr_d   = pick_idx + 2'd1;
        end
      end
      SETUP: begin
        state_d = ENABLE;
        e_d     = onehot(idx_q);
      end
      ENABLE: begin
        state_d = HOLD;
        ack_d   = onehot(gnt_q);
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      e_q     <= '0;
      ack_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign d      = d_q;
  assign e      = e_q;
  assign ack    = ack_q;
  assign gnt_id = gnt_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Directed, table-driven bench for latch_wr_arbiter with a few hand-written
// multi-cycle sequences and a continuous bus-stability monitor.
module tb_latch_wr_arbiter;

  localparam int W = 8;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req;
  logic [4*W-1:0]  din;
  logic [7:0]      addr;
  logic [W-1:0]    d;
  logic [3:0]      e;
  logic [3:0]      ack;
  logic            busy;
  logic [1:0]      gnt_id;

  int applied;
  int miscompares;

  latch_wr_arbiter #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .din    (din),
    .addr   (addr),
    .d      (d),
    .e      (e),
    .ack    (ack),
    .busy   (busy),
    .gnt_id (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din;
    logic [7:0]  addr;
    logic [7:0]  exp_d;
    logic [3:0]  exp_e;
    logic [3:0]  exp_ack;
    logic        exp_busy;
    logic [1:0]  exp_gnt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] DS = 32'h0000_00A5;
  localparam logic [7:0]  AS = 8'h02;
  localparam logic [31:0] DC = 32'h4433_2211;
  localparam logic [7:0]  AC = 8'h1B;

  task automatic v(input logic r, input logic [3:0] rq, input logic [31:0] di,
                   input logic [7:0] ad, input logic [7:0] ed, input logic [3:0] ee,
                   input logic [3:0] ea, input logic eb, input logic [1:0] eg);
    vec_t t;
    t.rst_n = r;  t.req = rq;   t.din = di;  t.addr = ad;
    t.exp_d = ed; t.exp_e = ee; t.exp_ack = ea; t.exp_busy = eb; t.exp_gnt = eg;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input int n, input vec_t t);
    applied++;
    if (d !== t.exp_d || e !== t.exp_e || ack !== t.exp_ack ||
        busy !== t.exp_busy || gnt_id !== t.exp_gnt) begin
      miscompares++;
      $display("FAIL vec%0d: got d=%h e=%b ack=%b busy=%b gnt=%0d expected d=%h e=%b ack=%b busy=%b gnt=%0d",
               n, d, e, ack, busy, gnt_id,
               t.exp_d, t.exp_e, t.exp_ack, t.exp_busy, t.exp_gnt);
    end
  endtask

  // Bus-stability and one-hot monitor, evaluated on the falling edge.
  logic [W-1:0] prev_d;
  logic [3:0]   prev_e;
  logic         prev_rst_n;
  initial begin
    prev_d     = '0;
    prev_e     = '0;
    prev_rst_n = 1'b0;
  end
  always @(negedge clk) begin
    if (rst_n && prev_rst_n) begin
      if ((e != 4'd0 || prev_e != 4'd0) && d !== prev_d) begin
        applied++;
        miscompares++;
        $display("FAIL d_stable: got d=%h expected d=%h around enable at %0t", d, prev_d, $time);
      end
      if ($countones(e) > 1 || $countones(ack) > 1) begin
        applied++;
        miscompares++;
        $display("FAIL onehot: got e=%b ack=%b expected at most one bit each at %0t", e, ack, $time);
      end
    end
    prev_d     = d;
    prev_e     = e;
    prev_rst_n = rst_n;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_ack, second_ack;
    applied     = 0;
    miscompares = 0;

    // Single write from reset
    v(1, 4'b0001, DS, AS, 8'hA5, 4'b0000, 4'b0000, 1, 0);
    v(1, 4'b0001, DS, AS, 8'hA5, 4'b0100, 4'b0000, 1, 0);
    v(1, 4'b0001, DS, AS, 8'hA5, 4'b0000, 4'b0001, 1, 0);
    v(1, 4'b0000, DS, AS, 8'hA5, 4'b0000, 4'b0000, 0, 0);
    v(1, 4'b0000, DS, AS, 8'hA5, 4'b0000, 4'b0000, 0, 0);
    // Reset, then full contention
    v(0, 4'b0000, DC, AC, 8'h00, 4'b0000, 4'b0000, 0, 0);
    v(1, 4'b1111, DC, AC, 8'h11, 4'b0000, 4'b0000, 1, 0);
    v(1, 4'b1111, DC, AC, 8'h11, 4'b1000, 4'b0000, 1, 0);
    v(1, 4'b1111, DC, AC, 8'h11, 4'b0000, 4'b0001, 1, 0);
    v(1, 4'b1110, DC, AC, 8'h11, 4'b0000, 4'b0000, 0, 0);
    v(1, 4'b1110, DC, AC, 8'h22, 4'b0000, 4'b0000, 1, 1);
    v(1, 4'b1110, DC, AC, 8'h22, 4'b0100, 4'b0000, 1, 1);
    v(1, 4'b1110, DC, AC, 8'h22, 4'b0000, 4'b0010, 1, 1);
    v(1, 4'b1100, DC, AC, 8'h22, 4'b0000, 4'b0000, 0, 1);
    v(1, 4'b1100, DC, AC, 8'h33, 4'b0000, 4'b0000, 1, 2);
    v(1, 4'b1100, DC, AC, 8'h33, 4'b0010, 4'b0000, 1, 2);
    v(1, 4'b1100, DC, AC, 8'h33, 4'b0000, 4'b0100, 1, 2);
    v(1, 4'b1000, DC, AC, 8'h33, 4'b0000, 4'b0000, 0, 2);
    v(1, 4'b1000, DC, AC, 8'h44, 4'b0000, 4'b0000, 1, 3);
    v(1, 4'b1000, DC, AC, 8'h44, 4'b0001, 4'b0000, 1, 3);
    v(1, 4'b1000, DC, AC, 8'h44, 4'b0000, 4'b1000, 1, 3);
    v(1, 4'b0000, DC, AC, 8'h44, 4'b0000, 4'b0000, 0, 3);
    // Late request from requester 3 while requester 1 is in ENABLE
    v(1, 4'b0010, DC, AC, 8'h22, 4'b0000, 4'b0000, 1, 1);
    v(1, 4'b0010, DC, AC, 8'h22, 4'b0100, 4'b0000, 1, 1);
    v(1, 4'b1010, DC, AC, 8'h22, 4'b0000, 4'b0010, 1, 1);
    v(1, 4'b1000, DC, AC, 8'h22, 4'b0000, 4'b0000, 0, 1);
    v(1, 4'b1000, DC, AC, 8'h44, 4'b0000, 4'b0000, 1, 3);
    v(1, 4'b1000, DC, AC, 8'h44, 4'b0001, 4'b0000, 1, 3);
    v(1, 4'b1000, DC, AC, 8'h44, 4'b0000, 4'b1000, 1, 3);
    v(1, 4'b0000, DC, AC, 8'h44, 4'b0000, 4'b0000, 0, 3);
    // Winner drops req mid-sequence; leaves ptr at 2
    v(1, 4'b0010, DC, AC, 8'h22, 4'b0000, 4'b0000, 1, 1);
    v(1, 4'b0000, DC, AC, 8'h22, 4'b0100, 4'b0000, 1, 1);
    v(1, 4'b0000, DC, AC, 8'h22, 4'b0000, 4'b0010, 1, 1);
    v(1, 4'b0000, DC, AC, 8'h22, 4'b0000, 4'b0000, 0, 1);
    // Fairness with ptr=2: requester 2 before 0
    v(1, 4'b0101, DC, AC, 8'h33, 4'b0000, 4'b0000, 1, 2);
    v(1, 4'b0101, DC, AC, 8'h33, 4'b0010, 4'b0000, 1, 2);
    v(1, 4'b0101, DC, AC, 8'h33, 4'b0000, 4'b0100, 1, 2);
    v(1, 4'b0001, DC, AC, 8'h33, 4'b0000, 4'b0000, 0, 2);
    v(1, 4'b0001, DC, AC, 8'h11, 4'b0000, 4'b0000, 1, 0);
    v(1, 4'b0001, DC, AC, 8'h11, 4'b1000, 4'b0000, 1, 0);
    v(1, 4'b0001, DC, AC, 8'h11, 4'b0000, 4'b0001, 1, 0);
    v(1, 4'b0000, DC, AC, 8'h11, 4'b0000, 4'b0000, 0, 0);

    rst_n = 1'b0;
    req   = '0;
    din   = DS;
    addr  = AS;
    #2;
    chk("reset_state", {d, e, ack, busy, gnt_id}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      din   = vecs[i].din;
      addr  = vecs[i].addr;
      @(posedge clk);
      #1;
      chk_vec(i, vecs[i]);
    end

    // Held request: requester 0 re-granted, acks 4 cycles apart
    first_ack  = -1;
    second_ack = -1;
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (ack == 4'b0001) begin
        if (first_ack < 0) first_ack = c;
        else if (second_ack < 0) second_ack = c;
      end
      if (c == 4) chk("held_idle_gap_busy", busy, 1'b0);
      if (c == 8) req = 4'b0000;
    end
    chk("held_first_ack", first_ack, 3);
    chk("held_second_ack", second_ack, 7);

    // Reset asserted during ENABLE
    req = 4'b0100;
    @(posedge clk);
    #1;
    chk("rst_seq_setup_gnt", gnt_id, 2'd2);
    @(posedge clk);
    #1;
    chk("rst_seq_enable_e", e, 4'b0010);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_e", e, 4'b0000);
    chk("rst_async_outs", {d, ack, busy, gnt_id}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_no_ack", ack, 4'b0000);
    req   = 4'b1010;
    rst_n = 1'b1;
    #1;
    chk("rst_release_no_grant", busy, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_ptr_zero_gnt", gnt_id, 2'd1);
    chk("rst_ptr_zero_d", d, 8'h22);
    req = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/latch_wr_arbiter.md
LATCH_WR_ARBITER -- requirements
Module: latch_wr_arbiter

Interface
REQ-001 Parameter: W, 8, data width of each latch in the bank.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  per-requester write request, bit i = requester i, level-held until its ack.
REQ-005 Port: din  input  4*W  packed write data, slice [i*W +: W] belongs to requester i.
REQ-006 Port: addr  input  8  packed target latch index, slice [i*2 +: 2] belongs to requester i.
REQ-007 Port: d  output  W  data bus to the 4-entry latch bank, registered.
REQ-008 Port: e  output  4  one-hot latch enable to the bank, registered.
REQ-009 Port: ack  output  4  one-cycle completion pulse to the granted requester, registered.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: gnt_id  output  2  index of the requester currently being served, registered.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SETUP, ENABLE, HOLD.
REQ-013 IDLE: if any req bit is high, the block SHALL grant one requester by round-robin, latch din and addr slices of the winner into d and an internal index register, set gnt_id, and go to SETUP; otherwise stay in IDLE.
REQ-014 Round-robin: search starts at pointer ptr and proceeds ptr, ptr+1, ... modulo 4; after a grant to i, ptr SHALL become (i+1) mod 4.
REQ-015 SETUP: e SHALL be 0 with d stable; next state ENABLE.
REQ-016 ENABLE: e SHALL equal the one-hot of the latched addr for exactly one cycle; d unchanged; next state HOLD.
REQ-017 HOLD: e SHALL be 0, d unchanged, ack[gnt_id] SHALL be 1 for this one cycle; next state IDLE.
REQ-018 Latency: req first sampled high at edge n -> SETUP from n, e high in cycle after edge n+1, ack high in cycle after edge n+2, IDLE after edge n+3.
REQ-019 d SHALL never change in a cycle where any e bit is high, nor in the cycle before or after it.
REQ-020 At most one e bit and at most one ack bit SHALL be high in any cycle.
REQ-021 req changes, including new requests, while busy SHALL be ignored; a winner dropping req mid-sequence SHALL NOT abort the sequence and its ack SHALL still pulse.
REQ-022 A requester still asserting req in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-023 Back-to-back grants SHALL be separated by at least one IDLE cycle; maximum throughput one write per 4 cycles.

Reset
REQ-024 While rst_n is low: state IDLE, e=0, ack=0, d=0, gnt_id=0, ptr=0, busy=0, immediately without waiting for clk.
REQ-025 Reset asserted mid-sequence SHALL drop e at once, and no ack SHALL be issued for the aborted write.
REQ-026 First grant after rst_n rises SHALL occur no earlier than the first rising clk edge with rst_n high.

Structure
REQ-027 State encodings and latch-bank depth constant 4 SHALL live in a shared package latch_pkg.
REQ-028 The round-robin selector (req, ptr -> valid, winner index) SHALL be one combinational sub-module rr_pick4.

Verification
REQ-029 Single write: req=4'b0001, din[7:0]=8'hA5, addr[1:0]=2 -> e=4'b0100 one cycle after SETUP, d=8'hA5 for SETUP..HOLD, ack=4'b0001 in HOLD.
REQ-030 Contention from reset: req=4'b1111 held, each dropped after its ack -> grant order 0,1,2,3, each write 4 cycles apart.
REQ-031 Fairness: ptr=2, req=4'b0101 -> requester 2 served first, then 0.
REQ-032 Late request: req[3] rises during ENABLE of requester 1 -> ignored until IDLE, then served; requester 1 write unaffected.
REQ-033 Reset in ENABLE: rst_n low mid-cycle -> e=0 before next clk edge, no ack, ptr=0 after release.
REQ-034 Held req: requester 0 keeps req high after ack with no other requests -> re-granted, new write completes with ack[0] 4 cycles after first.
